// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division step on a signed partial remainder and an
// unsigned quotient shift register.
module nr_div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next,
  output logic             is_add
);

  logic [WIDTH:0] r_sh;
  logic [WIDTH:0] d_ext;

  // Shifted remainder spans [-2D, 2D), which always fits WIDTH+1 signed bits.
  always_comb begin
    r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    d_ext  = {1'b0, d};
    is_add = r[WIDTH];
    r_next = is_add ? (r_sh + d_ext) : (r_sh - d_ext);
    q_next = {q[WIDTH-2:0], ~r_next[WIDTH]};
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: non-restoring core on operand magnitudes with
// sign fix-up, initiate/done handshake and add/subtract step counters.
module booth_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             initiate,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] count_add,
  output logic [CNT_W-1:0] count_sub,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             neg_n;
  logic             neg_d;
  logic [CNT_W-1:0] idx;

  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             step_add;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] dbz_rem;

  nr_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_step),
    .q_next (q_step),
    .is_add (step_add)
  );

  // Unsigned magnitudes keep |-2^(WIDTH-1)| exact.
  always_comb begin
    mag_n   = dividend[WIDTH-1] ? -dividend : dividend;
    mag_d   = divisor[WIDTH-1] ? -divisor : divisor;
    r_fix   = r[WIDTH] ? (r[WIDTH-1:0] + d) : r[WIDTH-1:0];
    q_out   = (neg_n ^ neg_d) ? -q : q;
    r_out   = neg_n ? -r_fix : r_fix;
    dbz_rem = neg_n ? -q : q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      neg_n       <= 1'b0;
      neg_d       <= 1'b0;
      idx         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count_add   <= '0;
      count_sub   <= '0;
      done        <= 1'b1;
    end else if (initiate) begin
      state       <= ITER;
      r           <= '0;
      q           <= mag_n;
      d           <= mag_d;
      neg_n       <= dividend[WIDTH-1];
      neg_d       <= divisor[WIDTH-1];
      idx         <= '0;
      count_add   <= '0;
      count_sub   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ITER: begin
          if (d == '0) begin
            quotient    <= DBZ_QUOTIENT;
            remainder   <= dbz_rem;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            r   <= r_step;
            q   <= q_step;
            idx <= idx + CNT_W'(1);
            if (step_add) count_add <= count_add + CNT_W'(1);
            else          count_sub <= count_sub + CNT_W'(1);
            if (idx == LAST_IDX) state <= FIX;
          end
        end
        FIX: begin
          quotient  <= q_out;
          remainder <= r_out;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider: directed corner cases plus random
// signed pairs against an arithmetic reference model.
module tb_booth_divider;

  logic        clk;
  logic        rst_n;
  logic        initiate;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [6:0]  count_add;
  logic [6:0]  count_sub;
  logic        done;

  int checks = 0;
  int errors = 0;

  booth_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .initiate    (initiate),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .count_add   (count_add),
    .count_sub   (count_sub),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive initiate high for 'hold' edges, then release it.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int hold);
    initiate = 1'b1;
    dividend = a;
    divisor  = b;
    for (int i = 0; i < hold; i++) tick();
    initiate = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  // Reference: truncating signed division done in 64-bit arithmetic.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eq, output logic [31:0] er,
                       output logic edbz, output int elat);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      eq = 32'hFFFF_FFFF; er = a; edbz = 1'b1; elat = 1;
    end else begin
      eq = 32'(sa / sb); er = 32'(sa % sb); edbz = 1'b0; elat = 33;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit props);
    logic [31:0] eq, er;
    logic        edbz;
    int          elat, lat;
    longint      sa, sb, sr;
    model(a, b, eq, er, edbz, elat);
    start_op(a, b, hold);
    wait_done(lat);
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".q"}, 64'(quotient), 64'(eq));
    check({tag, ".r"}, 64'(remainder), 64'(er));
    check({tag, ".dbz"}, 64'(div_by_zero), 64'(edbz));
    if (edbz) begin
      check({tag, ".cadd"}, 64'(count_add), 64'd0);
      check({tag, ".csub"}, 64'(count_sub), 64'd0);
    end else begin
      check({tag, ".csum"}, 64'(count_add) + 64'(count_sub), 64'd32);
      check({tag, ".sub1"}, 64'(count_sub >= 7'd1), 64'd1);
    end
    if (props && !edbz) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sr = longint'($signed(remainder));
      check({tag, ".recon"}, 64'(32'(quotient * divisor + remainder)), 64'(a));
      check({tag, ".rmag"}, 64'((sr < 0 ? -sr : sr) < (sb < 0 ? -sb : sb)), 64'd1);
      check({tag, ".rsign"}, 64'((sr == 0) || ((sr < 0) == (sa < 0))), 64'd1);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    rst_n    = 1'b0;
    initiate = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst.done", 64'(done), 64'd1);
    check("rst.q", 64'(quotient), 64'd0);
    check("rst.r", 64'(remainder), 64'd0);
    check("rst.dbz", 64'(div_by_zero), 64'd0);
    check("rst.cnt", 64'({count_add, count_sub}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Seed a nonzero result, then reset mid-operation.
    run_op("seed", 32'd77, 32'd5, 1, 1'b1);
    start_op(32'd1000, 32'd7, 1);
    for (int i = 0; i < 10; i++) tick();
    check("mid.busy", 64'(done), 64'd0);
    check("mid.hold", 64'(quotient), 64'd15);
    rst_n = 1'b0;
    #1;
    check("arst.done", 64'(done), 64'd1);
    check("arst.q", 64'(quotient), 64'd0);
    check("arst.r", 64'(remainder), 64'd0);
    check("arst.cnt", 64'({count_add, count_sub}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("d1000_7", 32'd1000, 32'd7, 1, 1'b1);

    run_op("pp", 32'd7, 32'd2, 1, 1'b1);
    run_op("np", -32'sd7, 32'd2, 1, 1'b1);
    run_op("pn", 32'd7, -32'sd2, 1, 1'b1);
    run_op("nn", -32'sd7, -32'sd2, 1, 1'b1);
    run_op("dbz", 32'd12345, 32'd0, 1, 1'b0);
    run_op("dbzneg", -32'sd9, 32'd0, 1, 1'b0);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("min_1", 32'h8000_0000, 32'd1, 1, 1'b1);
    run_op("zero", 32'd0, 32'd5, 1, 1'b1);
    run_op("small", 32'd5, 32'd7, 1, 1'b1);
    run_op("bigd", 32'd5, 32'h8000_0000, 1, 1'b1);

    // Restart while busy: only the second operation counts.
    start_op(32'd50, 32'd4, 1);
    for (int i = 0; i < 5; i++) tick();
    run_op("restart", 32'd100, 32'd3, 1, 1'b1);

    // Initiate held high: stays busy, latency from the last high edge.
    initiate = 1'b1;
    dividend = 32'd999;
    divisor  = 32'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold.busy", 64'(done), 64'd0);
    end
    run_op("hold", 32'd999, 32'd10, 1, 1'b1);

    for (int k = 0; k < 1000; k++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0: b = $urandom();
        1: b = 32'($urandom_range(1, 100));
        2: b = -32'($urandom_range(1, 100));
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 31) == 0) a = 32'h8000_0000;
      if (b == 32'd0) b = 32'd3;
      run_op("rand", a, b, 1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
